// File: rtl/greater_cmp_reg_if.sv
// rtl/greater_cmp_reg_if.sv - sample/result bundle for the registered magnitude comparator
interface greater_cmp_reg_if #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 16
);
   // sample side
   logic                 in_valid;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 cnt_clr;

   // result side
   logic                 out_valid;
   logic                 greater;
   logic                 equal;
   logic                 less;
   logic [CNT_WIDTH-1:0] greater_cnt;
   logic                 cnt_sat;

   // stimulus source drives samples and watches results
   modport master (
      output in_valid, a, b, signed_mode, cnt_clr,
      input  out_valid, greater, equal, less, greater_cnt, cnt_sat
   );

   // comparator consumes samples and produces results
   modport slave (
      input  in_valid, a, b, signed_mode, cnt_clr,
      output out_valid, greater, equal, less, greater_cnt, cnt_sat
   );
endinterface

// File: rtl/greater_cmp_reg.sv
// rtl/greater_cmp_reg.sv - registered a/b comparator with saturating greater count; optional GREATER_CMP_SIGNED_EN adds two's-complement compare
module greater_cmp_reg #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input logic              clk,
   input logic              reset,
   greater_cmp_reg_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]     a_cmp;
   logic [WIDTH-1:0]     b_cmp;
   logic                 gt_c;
   logic                 eq_c;
   logic                 lt_c;

   logic                 valid_q;
   logic                 valid_d;
   logic [2:0]           flags_q;   // {greater, equal, less}
   logic [2:0]           flags_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 sat_q;
   logic                 sat_d;

`ifdef GREATER_CMP_SIGNED_EN
   logic [WIDTH-1:0] sign_flip;

   // Flipping the sign bit maps two's-complement onto offset binary, so a
   // single unsigned comparator serves both modes.
   always_comb begin
      sign_flip            = '0;
      sign_flip[WIDTH-1]   = bus.signed_mode;
      a_cmp                = bus.a ^ sign_flip;
      b_cmp                = bus.b ^ sign_flip;
   end
`else
   logic unused_signed_mode;

   // Operands compared as-is; signed_mode has no effect in this build.
   always_comb begin
      a_cmp = bus.a;
      b_cmp = bus.b;
   end

   assign unused_signed_mode = bus.signed_mode;
`endif

   // Combinational compare of the conditioned operands.
   always_comb begin
      gt_c = (a_cmp > b_cmp);
      eq_c = (a_cmp == b_cmp);
      lt_c = (a_cmp < b_cmp);
   end

   // Next state: flags capture on a valid sample and hold otherwise; the
   // counter clear wins over a same-cycle increment.
   always_comb begin
      valid_d = bus.in_valid;
      flags_d = flags_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;

      if (bus.in_valid) begin
         flags_d = {gt_c, eq_c, lt_c};
      end

      if (bus.cnt_clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (bus.in_valid && gt_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
         sat_d = sat_q | (cnt_d == CNT_MAX);
      end
   end

   // State registers; reset discards any sample in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         flags_q <= 3'b000;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.greater     = flags_q[2];
   assign bus.equal       = flags_q[1];
   assign bus.less        = flags_q[0];
   assign bus.greater_cnt = cnt_q;
   assign bus.cnt_sat     = sat_q;

endmodule

// File: tb/tb_greater_cmp_reg.sv
// tb/tb_greater_cmp_reg.sv - self-checking bench for greater_cmp_reg (16-bit and 2-bit counter instances)
module tb_greater_cmp_reg;

   logic clk;
   logic reset;

   int n_checks;
   int n_errors;

   greater_cmp_reg_if #(.WIDTH(4), .CNT_WIDTH(16)) if16 ();
   greater_cmp_reg_if #(.WIDTH(4), .CNT_WIDTH(2))  if2  ();

   greater_cmp_reg #(.WIDTH(4), .CNT_WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (if16.slave)
   );

   greater_cmp_reg #(.WIDTH(4), .CNT_WIDTH(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (if2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int   m_valid;
   int   m_flags;   // 4 = greater, 2 = equal, 1 = less, 0 = none yet
   int   m_cnt16;
   int   m_cnt2;

   typedef struct {
      logic       v;
      logic [3:0] a;
      logic [3:0] b;
      logic       exp_valid;
      logic [2:0] exp_flags;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int operand_value(input logic [3:0] x, input logic sm);
      int r;
      bit signed_on;
      signed_on = 1'b0;
`ifdef GREATER_CMP_SIGNED_EN
      signed_on = 1'b1;
`endif
      r = int'(x);
      if (signed_on && sm && r >= 8) r = r - 16;
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_flags = 0;
      m_cnt16 = 0;
      m_cnt2  = 0;
   endtask

   task automatic model_update(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic sm, input logic clr);
      int  ai;
      int  bi;
      ai = operand_value(a, sm);
      bi = operand_value(b, sm);
      m_valid = v ? 1 : 0;
      if (v) m_flags = (ai > bi) ? 4 : (ai == bi) ? 2 : 1;
      if (clr) begin
         m_cnt16 = 0;
         m_cnt2  = 0;
      end else if (v && ai > bi) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3)      m_cnt2++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid16"}, 32'(if16.out_valid), 32'(m_valid));
      chk({tag, ".flags16"}, 32'({if16.greater, if16.equal, if16.less}), 32'(m_flags));
      chk({tag, ".cnt16"},   32'(if16.greater_cnt), 32'(m_cnt16));
      chk({tag, ".sat16"},   32'(if16.cnt_sat), 32'(m_cnt16 == 65535));
      chk({tag, ".flags2"},  32'({if2.greater, if2.equal, if2.less}), 32'(m_flags));
      chk({tag, ".cnt2"},    32'(if2.greater_cnt), 32'(m_cnt2));
      chk({tag, ".sat2"},    32'(if2.cnt_sat), 32'(m_cnt2 == 3));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".zero16"}, 32'({if16.out_valid, if16.greater, if16.equal, if16.less,
                                 if16.greater_cnt, if16.cnt_sat}), 32'd0);
      chk({tag, ".zero2"},  32'({if2.out_valid, if2.greater, if2.equal, if2.less,
                                 if2.greater_cnt, if2.cnt_sat}), 32'd0);
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic sm, input logic clr);
      if16.in_valid = v;  if16.a = a;  if16.b = b;  if16.signed_mode = sm;  if16.cnt_clr = clr;
      if2.in_valid  = v;  if2.a  = a;  if2.b  = b;  if2.signed_mode  = sm;  if2.cnt_clr  = clr;
   endtask

   task automatic step(input string tag, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic sm, input logic clr);
      drive(v, a, b, sm, clr);
      @(posedge clk);
      model_update(v, a, b, sm, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] word;
      n_checks = 0;
      n_errors = 0;
      model_reset();

      vecs[0] = '{v: 1'b1, a: 4'd5, b: 4'd3, exp_valid: 1'b1, exp_flags: 3'b100};
      vecs[1] = '{v: 1'b1, a: 4'd3, b: 4'd5, exp_valid: 1'b1, exp_flags: 3'b001};
      vecs[2] = '{v: 1'b1, a: 4'd9, b: 4'd9, exp_valid: 1'b1, exp_flags: 3'b010};
      vecs[3] = '{v: 1'b1, a: 4'hF, b: 4'h0, exp_valid: 1'b1, exp_flags: 3'b100};
      vecs[4] = '{v: 1'b1, a: 4'd2, b: 4'd7, exp_valid: 1'b1, exp_flags: 3'b001};
      vecs[5] = '{v: 1'b0, a: 4'd7, b: 4'd2, exp_valid: 1'b0, exp_flags: 3'b001};

      // reset held with a live greater sample on the inputs
      reset = 1'b1;
      drive(1'b1, 4'd5, 4'd3, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_hold");
      @(negedge clk);
      reset = 1'b0;
      step("after_reset", 1'b1, 4'd5, 4'd3, 1'b0, 1'b0);
      chk("after_reset.greater", 32'(if16.greater), 32'd1);
      chk("after_reset.out_valid", 32'(if16.out_valid), 32'd1);

      // table: basic compares and hold behaviour
      for (int i = 0; i < 6; i++) begin
         int cnt_before;
         cnt_before = m_cnt16;
         step($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
         chk($sformatf("vec%0d.flags", i), 32'({if16.greater, if16.equal, if16.less}),
             32'(vecs[i].exp_flags));
         chk($sformatf("vec%0d.valid", i), 32'(if16.out_valid), 32'(vecs[i].exp_valid));
         if (!vecs[i].v)
            chk($sformatf("vec%0d.cnt_hold", i), 32'(if16.greater_cnt), 32'(cnt_before));
      end

      // exhaustive sweep from a cleared counter
      step("pre_sweep_clr", 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++) begin
         word = 8'(i);
         step("sweep", 1'b1, word[7:4], word[3:0], 1'b0, 1'b0);
      end
      chk("sweep.cnt16_total", 32'(if16.greater_cnt), 32'd120);
      chk("sweep.sat2", 32'(if2.cnt_sat), 32'd1);

      // saturation and clear priority on the 2-bit counter
      step("sat_clr", 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("sat_run", 1'b1, 4'd6, 4'd1, 1'b0, 1'b0);
      chk("sat.cnt2", 32'(if2.greater_cnt), 32'd3);
      chk("sat.flag2", 32'(if2.cnt_sat), 32'd1);
      step("clr_prio", 1'b1, 4'd6, 4'd1, 1'b0, 1'b1);
      chk("clr_prio.cnt2", 32'(if2.greater_cnt), 32'd0);
      chk("clr_prio.sat2", 32'(if2.cnt_sat), 32'd0);
      chk("clr_prio.cnt16", 32'(if16.greater_cnt), 32'd0);
      chk("clr_prio.greater", 32'(if16.greater), 32'd1);

      // signed_mode: two's-complement when enabled, ignored otherwise
      step("sign1", 1'b1, 4'h8, 4'h7, 1'b1, 1'b0);
`ifdef GREATER_CMP_SIGNED_EN
      chk("sign1.less", 32'(if16.less), 32'd1);
`else
      chk("sign1.greater", 32'(if16.greater), 32'd1);
`endif
      step("sign0", 1'b1, 4'h8, 4'h7, 1'b0, 1'b0);
      chk("sign0.greater", 32'(if16.greater), 32'd1);

      // asynchronous reset mid-operation, checked before the next edge
      step("pre_async", 1'b1, 4'd9, 4'd2, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step("post_async", 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
              1'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
